// File: rtl/alu_wb_retire_buffer.sv
// In-order retire FIFO between alu_pipe and the register-file write port; commits CPSR and reports retired tags.
// Optional forwarding search of pending results is enabled with `define ALU_WB_FWD_EN.
module alu_wb_retire_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             exec_complete_in,
  input  logic             exec_confirmed_in,
  input  logic [3:0]       instr_tag_in,
  input  logic [3:0]       rd_addr_in,
  input  logic [31:0]      rd_data_in,
  input  logic [31:0]      cpsr_in,
  input  logic             rf_wr_ready_in,
`ifdef ALU_WB_FWD_EN
  input  logic [3:0]       fwd_addr_in,
  output logic             fwd_hit_out,
  output logic [31:0]      fwd_data_out,
`endif
  output logic             rf_wr_en_out,
  output logic [3:0]       rf_wr_addr_out,
  output logic [31:0]      rf_wr_data_out,
  output logic             cpsr_wr_en_out,
  output logic [31:0]      cpsr_out,
  output logic             retire_valid_out,
  output logic [3:0]       retire_tag_out,
  output logic [PTR_W:0]   count_out,
  output logic             full_out,
  output logic             overflow_out
);

  logic [DEPTH-1:0] conf_q;
  logic [3:0]       tag_q  [DEPTH];
  logic [3:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      cpsr_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic head_valid, head_conf, full, pop, push;

  assign head_valid = (count != '0);
  assign head_conf  = conf_q[rd_ptr];
  assign full       = (count == (PTR_W+1)'(DEPTH));
  // Unconfirmed heads carry no write, so they drain regardless of port readiness.
  assign pop        = head_valid && (!head_conf || rf_wr_ready_in);
  assign push       = exec_complete_in && (!full || pop);

  // Storage is cleared on reset so every head-derived output reads 0 while in reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      conf_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        cpsr_q[i] <= '0;
      end
    end else begin
      if (push) begin
        conf_q[wr_ptr] <= exec_confirmed_in;
        tag_q[wr_ptr]  <= instr_tag_in;
        addr_q[wr_ptr] <= rd_addr_in;
        data_q[wr_ptr] <= rd_data_in;
        cpsr_q[wr_ptr] <= cpsr_in;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
      if (exec_complete_in && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rf_wr_en_out     = head_valid && head_conf;
  assign rf_wr_addr_out   = addr_q[rd_ptr];
  assign rf_wr_data_out   = data_q[rd_ptr];
  assign cpsr_out         = cpsr_q[rd_ptr];
  assign retire_valid_out = pop;
  assign retire_tag_out   = tag_q[rd_ptr];
  assign cpsr_wr_en_out   = pop && head_conf;
  assign count_out        = count;
  assign full_out         = full;
  assign overflow_out     = overflow;

`ifdef ALU_WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    fwd_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && conf_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr_in)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_retire_buffer.sv
// Self-checking bench for alu_wb_retire_buffer: directed scenarios then random traffic against a queue model.
module tb_alu_wb_retire_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exec, conf, ready;
  logic [3:0]  tag, rd;
  logic [31:0] data, cpsr;
  logic        wr_en, cpsr_wr_en, ret_valid, full, ovf;
  logic [3:0]  wr_addr, ret_tag;
  logic [31:0] wr_data, cpsr_o;
  logic [2:0]  count;
`ifdef ALU_WB_FWD_EN
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  alu_wb_retire_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk_in(clk),
    .reset_n_in(reset_n),
    .exec_complete_in(exec),
    .exec_confirmed_in(conf),
    .instr_tag_in(tag),
    .rd_addr_in(rd),
    .rd_data_in(data),
    .cpsr_in(cpsr),
    .rf_wr_ready_in(ready),
`ifdef ALU_WB_FWD_EN
    .fwd_addr_in(fwd_addr),
    .fwd_hit_out(fwd_hit),
    .fwd_data_out(fwd_data),
`endif
    .rf_wr_en_out(wr_en),
    .rf_wr_addr_out(wr_addr),
    .rf_wr_data_out(wr_data),
    .cpsr_wr_en_out(cpsr_wr_en),
    .cpsr_out(cpsr_o),
    .retire_valid_out(ret_valid),
    .retire_tag_out(ret_tag),
    .count_out(count),
    .full_out(full),
    .overflow_out(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [3:0]  t;
    logic [3:0]  r;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t q[$];
  logic m_ovf;
  int   tests = 0;
  int   fails = 0;
  int   retired[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare all outputs against the queue model; returns whether the head retires this cycle.
  task automatic check_outputs(output bit pop);
    pop = 1'b0;
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 4));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    if (q.size() == 0) begin
      chk("wr_en_empty", 32'(wr_en), 0);
      chk("retire_empty", 32'(ret_valid), 0);
      chk("cpsr_wr_empty", 32'(cpsr_wr_en), 0);
    end else begin
      pop = !q[0].c || ready;
      chk("wr_en", 32'(wr_en), 32'(q[0].c));
      chk("wr_addr", 32'(wr_addr), 32'(q[0].r));
      chk("wr_data", wr_data, q[0].d);
      chk("cpsr", cpsr_o, q[0].p);
      chk("retire_valid", 32'(ret_valid), 32'(pop));
      chk("cpsr_wr_en", 32'(cpsr_wr_en), 32'(pop && q[0].c));
      if (pop) chk("retire_tag", 32'(ret_tag), 32'(q[0].t));
    end
`ifdef ALU_WB_FWD_EN
    begin
      bit          hit = 1'b0;
      logic [31:0] fd  = '0;
      foreach (q[i]) if (q[i].c && q[i].r == fwd_addr) begin hit = 1'b1; fd = q[i].d; end
      chk("fwd_hit", 32'(fwd_hit), 32'(hit));
      chk("fwd_data", fwd_data, fd);
    end
`endif
  endtask

  task automatic step(input logic ex, input logic cf, input logic [3:0] tg, input logic [3:0] ra,
                      input logic [31:0] dt, input logic [31:0] cp, input logic rdy);
    bit   pop;
    ent_t e;
    bit   room;
    exec = ex; conf = cf; tag = tg; rd = ra; data = dt; cpsr = cp; ready = rdy;
    @(negedge clk);
    check_outputs(pop);
    room = q.size() < 4;
    if (pop) begin
      retired.push_back(int'(q[0].t));
      void'(q.pop_front());
    end
    if (ex) begin
      if (room || pop) begin
        e.c = cf; e.t = tg; e.r = ra; e.d = dt; e.p = cp;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  // Asserts reset away from any clock edge, checks every output is 0, releases after the next edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    exec = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_retire", 32'(ret_valid), 0);
    chk("rst_cpsr_wr", 32'(cpsr_wr_en), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", wr_data, 0);
    chk("rst_cpsr", cpsr_o, 0);
    chk("rst_tag", 32'(ret_tag), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    exec = 1'b0; conf = 1'b0; ready = 1'b0;
    tag = '0; rd = '0; data = '0; cpsr = '0;
`ifdef ALU_WB_FWD_EN
    fwd_addr = 4'hF;
`endif
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single confirmed push with ready held high.
    step(1'b1, 1'b1, 4'd3, 4'd2, 32'h0000_000F, 32'h2000_0000, 1'b1);
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_addr", 32'(wr_addr), 2);
    chk("t1_tag", 32'(ret_tag), 3);
    idle(1'b1);
    idle(1'b1);
    chk("t1_count_after", 32'(count), 0);

    // Unconfirmed push retires without ready.
    step(1'b1, 1'b0, 4'd5, 4'd1, 32'h1234, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fill, overflow, then drain.
    retired.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 4'(i + 1), 32'(i * 16), 32'h4000_0000, 1'b0);
    idle(1'b0);
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf", 32'(ovf), 1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("t3_n_retired", 32'(retired.size()), 4);
    for (int i = 0; i < retired.size(); i++) chk("t3_order", 32'(retired[i]), 32'(i));

    // Full plus simultaneous push/pop is accepted without overflow.
    do_reset();
    retired.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(i + 1), 4'd3, 32'(i), 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'd9, 4'd3, 32'h99, 32'h0, 1'b1);
    chk("t4_count", 32'(count), 4);
    chk("t4_ovf", 32'(ovf), 0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("t4_n_retired", 32'(retired.size()), 5);
    if (retired.size() == 5) chk("t4_last_tag", 32'(retired[4]), 9);

    // Reset mid-drain discards pending entries.
    step(1'b1, 1'b1, 4'd6, 4'd4, 32'h66, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'd7, 4'd5, 32'h77, 32'h0, 1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);

`ifdef ALU_WB_FWD_EN
    step(1'b1, 1'b1, 4'd1, 4'd7, 32'h11, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'd2, 4'd7, 32'h22, 32'h0, 1'b0);
    fwd_addr = 4'd7;
    idle(1'b0);
    chk("fwd7_hit", 32'(fwd_hit), 1);
    chk("fwd7_data", fwd_data, 32'h22);
    fwd_addr = 4'd8;
    idle(1'b0);
    chk("fwd8_hit", 32'(fwd_hit), 0);
    do_reset();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
`ifdef ALU_WB_FWD_EN
      fwd_addr = 4'($urandom_range(0, 3));
`endif
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 3) != 0), 4'($urandom),
           4'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 99) < 45));
      if (i == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
